// File: rtl/seq_detector_param_if.sv
// Serial pattern detector bundle: sample/config inputs and match outputs.
// clk and reset remain plain ports on the detector.
interface seq_detector_param_if #(
  parameter int PAT_W = 8,
  parameter int CNT_W = 16,
  localparam int LEN_W = $clog2(PAT_W + 1)
) ();
  logic             en;
  logic             din;
  logic [PAT_W-1:0] pattern;
  logic [LEN_W-1:0] pat_len;
  logic             overlap;
  logic             clear;
  logic             z;
  logic [CNT_W-1:0] match_cnt;
  logic             cnt_sat;

  modport master (
    output en, din, pattern, pat_len, overlap, clear,
    input  z, match_cnt, cnt_sat
  );

  modport slave (
    input  en, din, pattern, pat_len, overlap, clear,
    output z, match_cnt, cnt_sat
  );
endinterface

// File: rtl/seq_detector_param.sv
// Moore serial pattern detector with programmable length,
// overlap mode and a saturating match counter.
module seq_detector_param #(
  parameter int PAT_W = 8,
  parameter int CNT_W = 16,
  localparam int LEN_W = $clog2(PAT_W + 1)
) (
  input logic clk,
  input logic reset,
  seq_detector_param_if.slave bus
);

  localparam logic [LEN_W-1:0] MAXL = LEN_W'(PAT_W);

  logic [PAT_W-1:0] hist;
  logic [PAT_W-1:0] hist_nx;
  logic [PAT_W-1:0] mask;
  logic [LEN_W-1:0] fill;
  logic [LEN_W-1:0] fill_nx;
  logic [LEN_W-1:0] eff_len;
  logic [CNT_W-1:0] cnt;
  logic             z;
  logic             sat;
  logic             hit;

  always_comb begin
    hist_nx = {hist[PAT_W-2:0], bus.din};
    fill_nx = (fill >= MAXL) ? MAXL : fill + 1'b1;
    eff_len = (bus.pat_len > MAXL) ? MAXL : bus.pat_len;
    // A full-width shift yields zero, so mask becomes all ones.
    mask    = ~({PAT_W{1'b1}} << eff_len);
    hit     = (eff_len != '0)
            && (fill_nx >= eff_len)
            && (((hist_nx ^ bus.pattern) & mask) == '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist <= '0;
      fill <= '0;
      z    <= 1'b0;
      cnt  <= '0;
      sat  <= 1'b0;
    end else if (bus.clear) begin
      hist <= '0;
      fill <= '0;
      z    <= 1'b0;
      cnt  <= '0;
      sat  <= 1'b0;
    end else if (bus.en) begin
      hist <= hist_nx;
      fill <= (hit && !bus.overlap) ? '0 : fill_nx;
      z    <= hit;
      if (hit) begin
        if (&cnt) sat <= 1'b1;
        else      cnt <= cnt + 1'b1;
      end
    end else begin
      z <= 1'b0;
    end
  end

  assign bus.z         = z;
  assign bus.match_cnt = cnt;
  assign bus.cnt_sat   = sat;

endmodule

// File: tb/tb_seq_detector_param.sv
// Scoreboard bench for seq_detector_param: stimulus pushes expected
// post-edge outputs, a monitor pops and compares after each edge.
module tb_seq_detector_param;

  localparam int PAT_W = 8;
  localparam int CNT_W = 2;

  logic clk;
  logic reset;

  seq_detector_param_if #(.PAT_W(PAT_W), .CNT_W(CNT_W)) bus ();

  seq_detector_param #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    string name;
    logic  z;
    int    cnt;
    logic  sat;
  } exp_t;

  exp_t sbq[$];
  int   ntests = 0;
  int   nfail  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int req);
    ntests++;
    if (act != req) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, req);
    end
  endtask

  task automatic chk_out(input string nm, input logic ez,
                         input int ecnt, input logic esat);
    chk({nm, ".z"}, int'(bus.z), int'(ez));
    chk({nm, ".cnt"}, int'(bus.match_cnt), ecnt);
    chk({nm, ".sat"}, int'(bus.cnt_sat), int'(esat));
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk_out(e.name, e.z, e.cnt, e.sat);
      end
    end
  end

  task automatic cyc(input string nm, input logic e, input logic d,
                     input logic clr, input logic ez, input int ecnt,
                     input logic esat);
    exp_t x;
    @(negedge clk);
    bus.en    = e;
    bus.din   = d;
    bus.clear = clr;
    x.name = nm;
    x.z    = ez;
    x.cnt  = ecnt;
    x.sat  = esat;
    sbq.push_back(x);
    @(posedge clk);
    #2;
  endtask

  task automatic cfg(input logic [PAT_W-1:0] p, input int len,
                     input logic ov);
    bus.pattern = p;
    bus.pat_len = 4'(len);
    bus.overlap = ov;
  endtask

  task automatic do_clear(input string nm);
    cyc(nm, 1'b1, 1'b1, 1'b1, 1'b0, 0, 1'b0);
  endtask

  logic [9:0] s1 = 10'b1111001100;
  logic [9:0] z1 = 10'b0000010001;
  int         c1[10] = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 2};

  initial begin : stim
    reset     = 1'b0;
    bus.en    = 1'b0;
    bus.din   = 1'b0;
    bus.clear = 1'b0;
    cfg('0, 0, 1'b1);
    #3;
    chk_out("reset", 1'b0, 0, 1'b0);
    @(negedge clk);
    reset = 1'b1;

    // compat: 1100 with overlap
    cfg(8'b1100, 4, 1'b1);
    for (int i = 0; i < 10; i++)
      cyc($sformatf("compat%0d", i), 1'b1, s1[9-i], 1'b0,
          z1[9-i], c1[i], 1'b0);
    do_clear("clr1");

    // 101 overlapping then non-overlapping
    cfg(8'b101, 3, 1'b1);
    cyc("ov1", 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    cyc("ov2", 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    cyc("ov3", 1'b1, 1'b1, 1'b0, 1'b1, 1, 1'b0);
    cyc("ov4", 1'b1, 1'b0, 1'b0, 1'b0, 1, 1'b0);
    cyc("ov5", 1'b1, 1'b1, 1'b0, 1'b1, 2, 1'b0);
    do_clear("clr2");
    cfg(8'b101, 3, 1'b0);
    cyc("nov1", 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    cyc("nov2", 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    cyc("nov3", 1'b1, 1'b1, 1'b0, 1'b1, 1, 1'b0);
    cyc("nov4", 1'b1, 1'b0, 1'b0, 1'b0, 1, 1'b0);
    cyc("nov5", 1'b1, 1'b1, 1'b0, 1'b0, 1, 1'b0);
    do_clear("clr3");

    // enable gating: stalled din values must be ignored
    cfg(8'b110, 3, 1'b1);
    cyc("en1", 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    cyc("st1", 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    cyc("st2", 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    cyc("st3", 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    cyc("en2", 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    cyc("st4", 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    cyc("st5", 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    cyc("st6", 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    cyc("en3", 1'b1, 1'b0, 1'b0, 1'b1, 1, 1'b0);
    cyc("st7", 1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b0);
    do_clear("clr4");

    // saturation of the 2-bit counter
    cfg(8'b1, 1, 1'b1);
    cyc("sat1", 1'b1, 1'b1, 1'b0, 1'b1, 1, 1'b0);
    cyc("sat2", 1'b1, 1'b1, 1'b0, 1'b1, 2, 1'b0);
    cyc("sat3", 1'b1, 1'b1, 1'b0, 1'b1, 3, 1'b0);
    cyc("sat4", 1'b1, 1'b1, 1'b0, 1'b1, 3, 1'b1);
    cyc("sat5", 1'b1, 1'b1, 1'b0, 1'b1, 3, 1'b1);
    cyc("sat6", 1'b0, 1'b1, 1'b0, 1'b0, 3, 1'b1);
    do_clear("clr5");

    // async reset mid-sequence, then clear beats a completing bit
    cfg(8'b1100, 4, 1'b1);
    cyc("rs1", 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    cyc("rs2", 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    cyc("rs3", 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    cyc("rs4", 1'b1, 1'b0, 1'b0, 1'b1, 1, 1'b0);
    cyc("rs5", 1'b1, 1'b1, 1'b0, 1'b0, 1, 1'b0);
    cyc("rs6", 1'b1, 1'b1, 1'b0, 1'b0, 1, 1'b0);
    cyc("rs7", 1'b1, 1'b0, 1'b0, 1'b0, 1, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    chk_out("async_rst", 1'b0, 0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    cyc("rs8", 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    cyc("cl1", 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    cyc("cl2", 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    cyc("cl3", 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    cyc("cl4", 1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b0);
    cyc("cl5", 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);

    // zero length never matches, oversize length clamps to PAT_W
    cfg(8'b0, 0, 1'b1);
    for (int i = 0; i < 4; i++)
      cyc($sformatf("len0_%0d", i), 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    do_clear("clr6");
    cfg(8'hFF, PAT_W + 3, 1'b1);
    for (int i = 0; i < 7; i++)
      cyc($sformatf("lenmax%0d", i), 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    cyc("lenmax7", 1'b1, 1'b1, 1'b0, 1'b1, 1, 1'b0);
    cyc("lenmax8", 1'b1, 1'b1, 1'b0, 1'b1, 2, 1'b0);
    cyc("lenmax9", 1'b1, 1'b0, 1'b0, 1'b0, 2, 1'b0);

    repeat (2) @(posedge clk);
    #2;
    chk("sb_drain", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
